// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan back-end.
// Glyphs are active-low, bit 0 = segment a ... bit 6 = segment g.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    typedef logic [1:0] digit_t;

    // Active-low one-hot anode pattern selecting a single digit.
    function automatic logic [3:0] anode_onehot(input digit_t d);
        return ~(4'b0001 << d);
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder; codes 10..15 show a dash.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Glyph lookup.
    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit common-anode display scanner for the countdown timer.
// Inputs are sampled once per frame into shadows so a frame is always
// self-consistent; adds leading-zero blanking, colon, alarm flash and tone.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV  = 25000,   // cycles per digit slot, at least 4
    parameter int FLASH_DIV = 250,     // frames per flash half-period
    parameter int TONE_DIV  = 12500    // cycles per tone half-period
) (
    input  logic       uclock,
    input  logic       reset,
    input  logic [3:0] num0,
    input  logic [3:0] num1,
    input  logic [3:0] num2,
    input  logic [3:0] num3,
    input  logic       buzzer,
    input  logic       colon_en,
    input  logic       blank_lz,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       buzz_out
);

    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int FLASH_W = $clog2(FLASH_DIV + 1);
    localparam int TONE_W  = $clog2(TONE_DIV + 1);

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SCAN_W-1:0]  GHOST_END  = SCAN_W'(2);
    localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_DIV - 1);
    localparam logic [TONE_W-1:0]  TONE_LAST  = TONE_W'(TONE_DIV - 1);

    logic [SCAN_W-1:0]  scan_cnt;
    digit_t             digit;
    logic [3:0]         sh_num [4];
    logic               sh_buzzer;
    logic               sh_colon;
    logic               sh_blank;
    logic [FLASH_W-1:0] frame_cnt;
    logic               phase;
    logic [TONE_W-1:0]  tone_cnt;
    logic               tone;

    logic       slot_end;
    logic       frame_end;
    logic       snap_now;
    logic       tone_active;
    logic       dark;
    logic       blank3;
    logic       blank2;
    logic       digit_blank;
    logic [3:0] cur_num;
    logic [6:0] cur_seg;

    assign slot_end    = (scan_cnt == SCAN_LAST);
    assign frame_end   = slot_end && (digit == digit_t'(3));
    assign snap_now    = (scan_cnt == '0) && (digit == digit_t'(0));
    assign tone_active = sh_buzzer && !phase;
    assign dark        = sh_buzzer && phase;
    assign cur_num     = sh_num[digit];

    bcd_to_seg7 u_dec (
        .bcd (cur_num),
        .seg (cur_seg)
    );

    // Slot timer; the digit index advances each time the slot timer wraps.
    always_ff @(posedge uclock or posedge reset) begin
        if (reset) begin
            scan_cnt <= '0;
            digit    <= '0;
        end else if (slot_end) begin
            scan_cnt <= '0;
            digit    <= digit + digit_t'(1);
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    // Frame-start capture of everything the display depends on.
    always_ff @(posedge uclock or posedge reset) begin
        if (reset) begin
            sh_num[0] <= '0;
            sh_num[1] <= '0;
            sh_num[2] <= '0;
            sh_num[3] <= '0;
            sh_buzzer <= 1'b0;
            sh_colon  <= 1'b0;
            sh_blank  <= 1'b0;
        end else if (snap_now) begin
            sh_num[0] <= num0;
            sh_num[1] <= num1;
            sh_num[2] <= num2;
            sh_num[3] <= num3;
            sh_buzzer <= buzzer;
            sh_colon  <= colon_en;
            sh_blank  <= blank_lz;
        end
    end

    // Alarm flash: phase flips every FLASH_DIV frames while the alarm is held.
    always_ff @(posedge uclock or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
            phase     <= 1'b0;
        end else if (!sh_buzzer) begin
            frame_cnt <= '0;
            phase     <= 1'b0;
        end else if (frame_end) begin
            if (frame_cnt == FLASH_LAST) begin
                frame_cnt <= '0;
                phase     <= !phase;
            end else begin
                frame_cnt <= frame_cnt + FLASH_W'(1);
            end
        end
    end

    // Buzzer square wave, running only during the lit half of the flash.
    always_ff @(posedge uclock or posedge reset) begin
        if (reset) begin
            tone_cnt <= '0;
            tone     <= 1'b0;
        end else if (!tone_active) begin
            tone_cnt <= '0;
            tone     <= 1'b0;
        end else if (tone_cnt == TONE_LAST) begin
            tone_cnt <= '0;
            tone     <= !tone;
        end else begin
            tone_cnt <= tone_cnt + TONE_W'(1);
        end
    end

    // Leading-zero blanking: a digit may only blank if everything left of it did.
    always_comb begin
        blank3      = sh_blank && (sh_num[3] == 4'd0);
        blank2      = blank3 && (sh_num[2] == 4'd0);
        digit_blank = 1'b0;
        case (digit)
            digit_t'(3): digit_blank = blank3;
            digit_t'(2): digit_blank = blank2;
            default:     digit_blank = 1'b0;
        endcase
    end

    // Output registers; anodes stay dark for the first two cycles of each slot.
    always_ff @(posedge uclock or posedge reset) begin
        if (reset) begin
            an       <= 4'hF;
            seg      <= SEG_BLANK;
            dp       <= 1'b1;
            buzz_out <= 1'b0;
        end else begin
            an       <= (scan_cnt < GHOST_END || digit_blank || dark) ? 4'hF
                                                                      : anode_onehot(digit);
            seg      <= digit_blank ? SEG_BLANK : cur_seg;
            dp       <= !((digit == digit_t'(2)) && sh_colon);
            buzz_out <= tone_active && tone;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: the stimulus side predicts each frame's
// display slots and every cycle's buzzer level from the frame snapshot;
// an independent monitor pops and compares as the DUT presents them.
`timescale 1ns/1ps
module tb_seg7_scan;

    localparam int SD    = 4;
    localparam int FD    = 2;
    localparam int TD    = 3;
    localparam int FRAME = 4 * SD;

    logic       uclock   = 1'b0;
    logic       reset    = 1'b1;
    logic [3:0] num0     = 4'd4;
    logic [3:0] num1     = 4'd3;
    logic [3:0] num2     = 4'd2;
    logic [3:0] num3     = 4'd1;
    logic       buzzer   = 1'b0;
    logic       colon_en = 1'b1;
    logic       blank_lz = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       buzz_out;

    seg7_scan #(
        .SCAN_DIV  (SD),
        .FLASH_DIV (FD),
        .TONE_DIV  (TD)
    ) dut (
        .uclock   (uclock),
        .reset    (reset),
        .num0     (num0),
        .num1     (num1),
        .num2     (num2),
        .num3     (num3),
        .buzzer   (buzzer),
        .colon_en (colon_en),
        .blank_lz (blank_lz),
        .an       (an),
        .seg      (seg),
        .dp       (dp),
        .buzz_out (buzz_out)
    );

    always #5 uclock = ~uclock;

    typedef struct {
        int         n;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } disp_t;

    disp_t disp_q[$];
    logic  buzz_q[$];
    int    checks    = 0;
    int    failures  = 0;
    int    edge_n    = 0;
    bit    mon_en    = 1'b0;
    bit    rst_chk   = 1'b0;
    bit    final_chk = 1'b0;

    // reference model state
    bit prev_buz   = 1'b0;
    int run_idx    = 0;
    bit phase_f    = 1'b0;
    bit snap_buz   = 1'b0;
    bit act_prev   = 1'b0;
    int tone_start = 0;

    logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                               7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

    task automatic model_reset();
        mon_en     = 1'b0;
        edge_n     = 0;
        prev_buz   = 1'b0;
        run_idx    = 0;
        phase_f    = 1'b0;
        snap_buz   = 1'b0;
        act_prev   = 1'b0;
        tone_start = 0;
        disp_q.delete();
        buzz_q.delete();
    endtask

    // Frame start: record what the display latched and predict every settled slot.
    task automatic snapshot();
        int    nums [4];
        bit    b3;
        bit    b2;
        bit    blank;
        disp_t e;
        nums[0] = int'(num0);
        nums[1] = int'(num1);
        nums[2] = int'(num2);
        nums[3] = int'(num3);
        snap_buz = buzzer;
        if (snap_buz) run_idx = prev_buz ? run_idx + 1 : 0;
        prev_buz = snap_buz;
        phase_f  = snap_buz && (((run_idx / FD) % 2) == 1);
        b3 = blank_lz && (nums[3] == 0);
        b2 = b3 && (nums[2] == 0);
        for (int d = 0; d < 4; d++) begin
            blank = (d == 3) ? b3 : ((d == 2) ? b2 : 1'b0);
            for (int s = 2; s < SD; s++) begin
                e.n   = edge_n + SD * d + s;
                e.an  = (blank || phase_f) ? 4'hF : ~(4'b0001 << d);
                e.seg = blank ? 7'h7F : glyph[nums[d]];
                e.dp  = !((d == 2) && colon_en);
                disp_q.push_back(e);
            end
        end
    endtask

    task automatic tick();
        int pos;
        bit b;
        bit a;
        @(posedge uclock);
        edge_n++;
        pos = (edge_n - 1) % FRAME;
        if (pos == 0) snapshot();
        b = act_prev && ((((edge_n - 1 - tone_start) / TD) % 2) == 1);
        buzz_q.push_back(b);
        if (pos == FRAME - 1)
            a = snap_buz && ((((run_idx + 1) / FD) % 2) == 0);
        else
            a = snap_buz && !phase_f;
        if (a && !act_prev) tone_start = edge_n;
        act_prev = a;
        mon_en   = 1'b1;
        #1;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_digits(input int d3, input int d2, input int d1, input int d0);
        num3 = 4'(d3);
        num2 = 4'(d2);
        num1 = 4'(d1);
        num0 = 4'(d0);
    endtask

    task automatic drive_random();
        num0     = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        num1     = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        num2     = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        num3     = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        colon_en = 1'($urandom_range(0, 1));
        blank_lz = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 5) == 0) buzzer = !buzzer;
    endtask

    always @(negedge uclock) begin : monitor
        disp_t d;
        logic  eb;
        if (reset) begin
            if (rst_chk) begin
                checks++;
                if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || buzz_out !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_outputs t=%0t: got an=%b seg=%b dp=%b buzz=%b, want an=1111 seg=1111111 dp=1 buzz=0",
                             $time, an, seg, dp, buzz_out);
                end
            end
        end else if (final_chk) begin
            checks++;
            if (disp_q.size() != 0 || buzz_q.size() != 0) begin
                failures++;
                $display("FAIL drain: %0d display and %0d buzzer expectations left, want 0 and 0",
                         disp_q.size(), buzz_q.size());
            end
        end else if (mon_en) begin
            checks++;
            if (buzz_q.size() == 0) begin
                failures++;
                $display("FAIL buzz_underflow edge=%0d: no expectation queued", edge_n);
            end else begin
                eb = buzz_q.pop_front();
                if (buzz_out !== eb) begin
                    failures++;
                    $display("FAIL buzz edge=%0d: got %b want %b", edge_n, buzz_out, eb);
                end
            end
            if (an !== 4'hF || (disp_q.size() > 0 && disp_q[0].n == edge_n)) begin
                checks++;
                if (disp_q.size() == 0) begin
                    failures++;
                    $display("FAIL disp_unexpected edge=%0d: got an=%b seg=%b dp=%b, want nothing lit",
                             edge_n, an, seg, dp);
                end else begin
                    d = disp_q.pop_front();
                    if (d.n != edge_n || an !== d.an || seg !== d.seg || dp !== d.dp) begin
                        failures++;
                        $display("FAIL disp: got edge=%0d an=%b seg=%b dp=%b, want edge=%0d an=%b seg=%b dp=%b",
                                 edge_n, an, seg, dp, d.n, d.an, d.seg, d.dp);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        @(posedge uclock);
        rst_chk = 1'b1;
        repeat (3) @(posedge uclock);
        #2;
        rst_chk = 1'b0;
        reset   = 1'b0;

        // digits 1,2,3,4 with colon, no blanking
        run_ticks(2 * FRAME);

        // leading-zero blanking
        blank_lz = 1'b1;
        set_digits(0, 0, 0, 7);
        run_ticks(FRAME);
        set_digits(0, 5, 0, 7);
        run_ticks(FRAME);
        set_digits(0, 0, 0, 0);
        run_ticks(FRAME);
        set_digits(15, 0, 0, 9);
        run_ticks(FRAME);

        // mid-frame change must wait for the next frame
        blank_lz = 1'b0;
        set_digits(1, 2, 3, 4);
        run_ticks(FRAME);
        run_ticks(2 * SD + 1);
        num0 = 4'd5;
        run_ticks(FRAME - 2 * SD - 1);
        run_ticks(FRAME);

        // invalid BCD
        num1 = 4'hC;
        run_ticks(FRAME);

        // alarm on, then off
        buzzer = 1'b1;
        run_ticks(6 * FRAME);
        buzzer = 1'b0;
        run_ticks(2 * FRAME);

        // randomized frames, inputs changing at a random point in each frame
        for (int f = 0; f < 40; f++) begin
            int r;
            r = $urandom_range(0, FRAME - 1);
            for (int p = 0; p < FRAME; p++) begin
                tick();
                if (p == r) drive_random();
            end
        end

        // asynchronous reset while a digit is lit and the alarm is sounding
        buzzer = 1'b0;
        set_digits(1, 2, 3, 4);
        blank_lz = 1'b0;
        run_ticks(FRAME);
        buzzer = 1'b1;
        run_ticks(FRAME + SD + 3);
        #2;
        reset   = 1'b1;
        rst_chk = 1'b1;
        model_reset();
        repeat (2) @(posedge uclock);
        #2;
        rst_chk = 1'b0;
        reset   = 1'b0;
        run_ticks(3 * FRAME);

        @(negedge uclock);
        #1;
        mon_en    = 1'b0;
        final_chk = 1'b1;
        @(negedge uclock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
